rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Parametrised reset sequencer that generalises the two-flop reset synchroniser. It synchronises an external active-low reset request through a configurable flop chain and enforces a minimum assertion width. It then releases NUM_CH downstream reset outputs one by one with a programmable gap, and supports per-channel software reset pulses after the sequence completes. It sits at the top level, between the reset source and the per-block reset inputs (register file, ALU, UART, FIFO domains).

## Interface
- NUM_CH, 4: number of reset output channels; must be ≥1.
- NUM_STAGES, 2: synchroniser depth for RST_REQ_N; must be ≥2.
- HOLD_CYCLES, 8: minimum low time of every reset output, in CLK cycles; must be ≥1.
- GAP_CYCLES, 4: cycles between successive channel releases; must be ≥1.
- CNT_WIDTH, 8: counter width; HOLD_CYCLES and GAP_CYCLES must both be ≤ 2^CNT_WIDTH−1.
- CLK  in  1  single clock for the whole block.
- RST  in  1  reset, synchronous, active-low; sampled only on the CLK rising edge.
- RST_REQ_N  in  1  external reset request, active-low, asynchronous to CLK.
- SW_RST  in  NUM_CH  per-channel software reset request; active-high, single-cycle pulse.
- SYNC_RST  out  NUM_CH  per-channel reset outputs, active-low; bit 0 is released first.
- SEQ_DONE  out  1  high once all channels have been released by the power-on sequence.
- BUSY  out  1  high while any SYNC_RST bit is low.

## Operation
- The synchroniser chain has NUM_STAGES flops that shift in RST_REQ_N. req_sync is the last stage.
- FSM states:
  - ASSERT: all SYNC_RST=0. Moves to HOLD on the edge where req_sync=1; cnt←0.
  - HOLD: if cnt==HOLD_CYCLES−1, set SYNC_RST[0]←1, idx←1, cnt←0, and move to GAP. If NUM_CH==1, move straight to RUN instead. Otherwise cnt++.
  - GAP: if cnt==GAP_CYCLES−1, set SYNC_RST[idx]←1, cnt←0, idx++. When idx was NUM_CH−1, move to RUN and set SEQ_DONE←1 on the same edge. Otherwise cnt++.
  - RUN: SEQ_DONE=1. Per-channel software resets are active.
- Software reset, per channel i, RUN state only:
  - SW_RST[i]=1 forces SYNC_RST[i]←0 and loads that channel's counter scnt[i]←0.
  - Each later cycle increments scnt[i]. When scnt[i]==HOLD_CYCLES−1, SYNC_RST[i]←1.
  - Channels run independently; any number may be in software reset at once.
  - A new SW_RST[i] while channel i is already in software reset restarts scnt[i] at 0, extending the hold.
  - SW_RST is ignored in ASSERT, HOLD and GAP.
- Request abort: req_sync=0 in any state sends the FSM to ASSERT on that edge. All SYNC_RST←0, SEQ_DONE←0, cnt, idx and all scnt←0. This takes priority over SW_RST.
- BUSY is combinational: BUSY = ~&SYNC_RST.

## Timing
- RST=0 at a rising edge sets, on that edge: all sync flops←0, state←ASSERT, cnt←0, idx←0, scnt←0, SYNC_RST←0, SEQ_DONE←0. BUSY therefore reads 1.
- Release schedule, with RST_REQ_N first sampled high at edge 1 and no aborts:
  - req_sync rises after edge NUM_STAGES.
  - HOLD is entered at edge NUM_STAGES+1.
  - SYNC_RST[k] rises after edge NUM_STAGES+1+HOLD_CYCLES+k·GAP_CYCLES.
  - SEQ_DONE rises on the same edge as SYNC_RST[NUM_CH−1].
- Abort latency: RST_REQ_N low sampled at edge e makes all outputs low after edge e+NUM_STAGES. The RST_REQ_N glitch filter is only the synchroniser; a low of one cycle that reaches req_sync restarts the full sequence.
- Software reset: SW_RST[i] sampled at edge e makes SYNC_RST[i] low after edge e and high again after edge e+HOLD_CYCLES.
- No output glitches: every output except BUSY comes directly from a flop.

## Test plan
- Power-on, defaults: RST low for 3 cycles, then high, with RST_REQ_N high from the start → SYNC_RST=0000 until the schedule above; bits rise 4 cycles apart, and SEQ_DONE=1 together with SYNC_RST=1111.
- Mid-sequence abort: RST_REQ_N low for 1 cycle just after SYNC_RST becomes 0011 → 2 cycles later SYNC_RST=0000 and SEQ_DONE=0; the full sequence then restarts, and channel 0 rises HOLD_CYCLES+1 cycles after req_sync returns high.
- Software reset: in RUN, pulse SW_RST=0100 → SYNC_RST=1011 for exactly 8 cycles, BUSY=1 throughout, SEQ_DONE stays 1, other channels untouched.
- Overlapping software resets: SW_RST[1] at cycle t, SW_RST[3] at t+3, SW_RST[1] again at t+5 → channel 3 rises after t+11; channel 1 rises after t+13.
- Ignored request plus RST priority: SW_RST=1111 pulsed during HOLD → no effect on timing. RST low during RUN with a simultaneous SW_RST → all outputs at reset values after that edge.
- Parameter corner: NUM_CH=1, NUM_STAGES=3, HOLD_CYCLES=1, GAP_CYCLES=1 → SYNC_RST[0] and SEQ_DONE rise after edge 5.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer. Synchronises an active-low reset request,
// holds every channel in reset for a minimum width, releases the channels in
// order with a fixed gap, then offers per-channel software reset pulses.
module rst_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int NUM_STAGES  = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RST_REQ_N,
  input  logic [NUM_CH-1:0] SW_RST,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              SEQ_DONE,
  output logic              BUSY
);

  // idx has to hold values up to NUM_CH, so one extra code point is needed
  localparam int IDX_W = $clog2(NUM_CH + 1);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_GAP    = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [NUM_STAGES-1:0] sync_chain;
  logic                  req_sync;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [NUM_CH-1:0]     sync_rst;
  logic [NUM_CH-1:0]     sync_rst_nxt;
  logic                  seq_done;
  logic                  seq_done_nxt;
  logic [CNT_WIDTH-1:0]  scnt     [NUM_CH];
  logic [CNT_WIDTH-1:0]  scnt_nxt [NUM_CH];

  // Request synchroniser: shift RST_REQ_N through NUM_STAGES flops
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[NUM_STAGES-2:0], RST_REQ_N};
    end
  end

  assign req_sync = sync_chain[NUM_STAGES-1];

  // Sequencer state, counters and output flops
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      sync_rst <= '0;
      seq_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        scnt[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      sync_rst <= sync_rst_nxt;
      seq_done <= seq_done_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        scnt[i] <= scnt_nxt[i];
      end
    end
  end

  // Next-state and next-output logic; a low req_sync overrides everything
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    sync_rst_nxt = sync_rst;
    seq_done_nxt = seq_done;
    for (int i = 0; i < NUM_CH; i++) begin
      scnt_nxt[i] = scnt[i];
    end

    if (!req_sync) begin
      state_nxt    = ST_ASSERT;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      sync_rst_nxt = '0;
      seq_done_nxt = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        scnt_nxt[i] = '0;
      end
    end else begin
      unique case (state)
        ST_ASSERT: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end

        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            sync_rst_nxt[0] = 1'b1;
            cnt_nxt         = '0;
            idx_nxt         = IDX_W'(1);
            if (NUM_CH == 1) begin
              // single channel: the hold release is also the last release
              state_nxt    = ST_RUN;
              seq_done_nxt = 1'b1;
            end else begin
              state_nxt = ST_GAP;
            end
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx == IDX_W'(k)) begin
                sync_rst_nxt[k] = 1'b1;
              end
            end
            cnt_nxt = '0;
            idx_nxt = idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state_nxt    = ST_RUN;
              seq_done_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end

        ST_RUN: begin
          // each channel runs its own software-reset hold independently;
          // a low output bit in RUN means that channel is mid-hold
          for (int k = 0; k < NUM_CH; k++) begin
            if (SW_RST[k]) begin
              sync_rst_nxt[k] = 1'b0;
              scnt_nxt[k]     = '0;
            end else if (!sync_rst[k]) begin
              if (scnt[k] == HOLD_LAST) begin
                sync_rst_nxt[k] = 1'b1;
              end else begin
                scnt_nxt[k] = scnt[k] + CNT_WIDTH'(1);
              end
            end
          end
        end

        default: begin
          state_nxt = ST_ASSERT;
        end
      endcase
    end
  end

  assign SYNC_RST = sync_rst;
  assign SEQ_DONE = seq_done;
  assign BUSY     = ~&sync_rst;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: drives two sequencer configurations (defaults and a
// single-channel corner) from shared stimulus and compares them every cycle
// against a release-time model, plus fixed literal expectations.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req_n;
  logic [3:0] sw_rst;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NC = (g == 0) ? 4 : 1;
    localparam int NS = (g == 0) ? 2 : 3;
    localparam int HC = (g == 0) ? 8 : 1;
    localparam int GC = (g == 0) ? 4 : 1;
    localparam int DONE_AGE = 1 + HC + (NC - 1) * GC;

    logic [NC-1:0] sync_rst;
    logic          seq_done;
    logic          busy;

    rst_seq_ctrl #(
      .NUM_CH      (NC),
      .NUM_STAGES  (NS),
      .HOLD_CYCLES (HC),
      .GAP_CYCLES  (GC),
      .CNT_WIDTH   (8)
    ) dut (
      .CLK       (clk),
      .RST       (rst),
      .RST_REQ_N (rst_req_n),
      .SW_RST    (sw_rst[NC-1:0]),
      .SYNC_RST  (sync_rst),
      .SEQ_DONE  (seq_done),
      .BUSY      (busy)
    );

    // Model: age = consecutive edges the sequencer has seen the synchronised
    // request high; channel k is out of reset once age >= 1+HC+k*GC, unless a
    // software pulse taken in the completed phase set a later release edge.
    int            age;
    int            edge_n;
    int            sw_rel [NC];
    logic          hist   [NS];
    logic [NC-1:0] exp_rst;
    logic          exp_done;
    logic          req;

    initial begin
      age      = 0;
      edge_n   = 0;
      exp_rst  = '0;
      exp_done = 1'b0;
      req      = 1'b0;
      for (int k = 0; k < NC; k++) sw_rel[k] = 0;
      for (int i = 0; i < NS; i++) hist[i] = 1'b0;
      forever begin
        @(posedge clk);
        edge_n++;
        if (!rst) begin
          age = 0;
          for (int k = 0; k < NC; k++) sw_rel[k] = 0;
          for (int i = 0; i < NS; i++) hist[i] = 1'b0;
        end else begin
          req = hist[NS-1];
          if (!req) begin
            age = 0;
            for (int k = 0; k < NC; k++) sw_rel[k] = 0;
          end else begin
            if (age >= DONE_AGE) begin
              for (int k = 0; k < NC; k++) begin
                if (sw_rst[k]) sw_rel[k] = edge_n + HC;
              end
            end
            age++;
          end
          for (int i = NS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = rst_req_n;
        end
        for (int k = 0; k < NC; k++) begin
          exp_rst[k] = (age >= 1 + HC + k * GC) && (edge_n >= sw_rel[k]);
        end
        exp_done = (age >= DONE_AGE);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("c0_sync", 32'(cfg[0].sync_rst), 32'(cfg[0].exp_rst));
    chk("c0_done", 32'(cfg[0].seq_done), 32'(cfg[0].exp_done));
    chk("c0_busy", 32'(cfg[0].busy),     32'(!(&cfg[0].exp_rst)));
    chk("c1_sync", 32'(cfg[1].sync_rst), 32'(cfg[1].exp_rst));
    chk("c1_done", 32'(cfg[1].seq_done), 32'(cfg[1].exp_done));
    chk("c1_busy", 32'(cfg[1].busy),     32'(!(&cfg[1].exp_rst)));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // hand-computed expectations for the default configuration
  task automatic lit0(input string name, input logic [3:0] s, input logic d);
    chk({name, "_sync"},  32'(cfg[0].sync_rst), 32'(s));
    chk({name, "_done"},  32'(cfg[0].seq_done), 32'(d));
    chk({name, "_busy"},  32'(cfg[0].busy),     32'(!(&s)));
    chk({name, "_model"}, 32'(cfg[0].exp_rst),  32'(s));
  endtask

  // hand-computed expectations for the single-channel corner
  task automatic lit1(input string name, input logic s, input logic d);
    chk({name, "_sync"},  32'(cfg[1].sync_rst), 32'(s));
    chk({name, "_done"},  32'(cfg[1].seq_done), 32'(d));
    chk({name, "_model"}, 32'(cfg[1].exp_done), 32'(d));
  endtask

  initial begin
    rst       = 1'b0;
    rst_req_n = 1'b1;
    sw_rst    = 4'b0000;

    // reset state
    tick();
    lit0("rst_c0", 4'b0000, 1'b0);
    lit1("rst_c1", 1'b0, 1'b0);
    run_to(3);
    rst = 1'b1;

    // power-on sequence: first request edge with RST high is edge 4
    run_to(7);   lit1("po_c1_7", 1'b0, 1'b0);
    run_to(8);   lit1("po_c1_8", 1'b1, 1'b1);
    run_to(13);  lit0("po13", 4'b0000, 1'b0);
    run_to(14);  lit0("po14", 4'b0001, 1'b0);
    run_to(17);  lit0("po17", 4'b0001, 1'b0);
    run_to(18);  lit0("po18", 4'b0011, 1'b0);
    run_to(22);  lit0("po22", 4'b0111, 1'b0);
    run_to(25);  lit0("po25", 4'b0111, 1'b0);
    run_to(26);  lit0("po26", 4'b1111, 1'b1);

    // one-cycle request low in RUN restarts the sequence
    run_to(30);
    rst_req_n = 1'b0;
    tick();
    rst_req_n = 1'b1;
    run_to(32);  lit0("ab32", 4'b1111, 1'b1);
    run_to(33);  lit0("ab33", 4'b0000, 1'b0);
    run_to(45);  lit0("ab45", 4'b0001, 1'b0);
    run_to(46);  lit0("ab46", 4'b0011, 1'b0);

    // mid-sequence abort right after 0011
    rst_req_n = 1'b0;
    tick();
    rst_req_n = 1'b1;
    run_to(48);  lit0("mid48", 4'b0011, 1'b0);
    run_to(49);  lit0("mid49", 4'b0000, 1'b0);
    run_to(57);  lit0("mid57", 4'b0000, 1'b0);
    run_to(58);  lit0("mid58", 4'b0001, 1'b0);

    // single software reset on channel 2
    run_to(75);
    sw_rst = 4'b0100;
    tick();
    sw_rst = 4'b0000;
    lit0("sw76", 4'b1011, 1'b1);
    run_to(83);  lit0("sw83", 4'b1011, 1'b1);
    run_to(84);  lit0("sw84", 4'b1111, 1'b1);

    // overlapping software resets: ch1 at 90, ch3 at 93, ch1 again at 95
    run_to(89);
    sw_rst = 4'b0010;
    tick();
    sw_rst = 4'b0000;
    run_to(92);
    sw_rst = 4'b1000;
    tick();
    sw_rst = 4'b0000;
    run_to(94);
    sw_rst = 4'b0010;
    tick();
    sw_rst = 4'b0000;
    run_to(100); lit0("ov100", 4'b0101, 1'b1);
    run_to(101); lit0("ov101", 4'b1101, 1'b1);
    run_to(102); lit0("ov102", 4'b1101, 1'b1);
    run_to(103); lit0("ov103", 4'b1111, 1'b1);

    // RST beats a simultaneous software request
    run_to(110);
    rst    = 1'b0;
    sw_rst = 4'b1111;
    tick();
    rst    = 1'b1;
    sw_rst = 4'b0000;
    lit0("rp111", 4'b0000, 1'b0);
    lit1("rp111_c1", 1'b0, 1'b0);

    // software request during HOLD leaves the schedule unchanged
    run_to(116);
    sw_rst = 4'b1111;
    tick();
    sw_rst = 4'b0000;
    run_to(121); lit0("ig121", 4'b0000, 1'b0);
    run_to(122); lit0("ig122", 4'b0001, 1'b0);
    run_to(133); lit0("ig133", 4'b0111, 1'b0);
    run_to(134); lit0("ig134", 4'b1111, 1'b1);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      rst_req_n = ($urandom_range(0, 59) != 0);
      for (int k = 0; k < 4; k++) sw_rst[k] = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst       = 1'b1;
    rst_req_n = 1'b1;
    sw_rst    = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
